sia_rx_fifo: RTL and testbench

//  Receive-side FIFO of the SIA, directly downstream of the V.4 bit-serial receiver.
//  - Detects end-of-frame (receiver idle 0->1) and captures the receiver's 16-bit shift register.
//  - Right-justifies the captured word by the frame length and queues it for the Wishbone slave.
//  - Flags overrun when a frame completes while the FIFO is full.

---
 rtl/sia_rx_fifo.sv | 140 ++++++++++++++
 tb/tb_sia_rx_fifo.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/sia_rx_fifo.sv
// sia_rx_fifo: receive-side FIFO of the SIA.
// It captures the bit-serial receiver's shift register at end of frame, right-justifies
// the word by the frame length, and queues it for the Wishbone slave with first-word-fall-through.
// A frame that completes while the FIFO is full is dropped and raises a sticky overrun flag.
module sia_rx_fifo #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned DEPTH_BITS = 4
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [DATA_WIDTH-1:0] rx_dat_i,
  input  logic                  rx_idle_i,
  input  logic [5:0]            bits_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  input  logic                  clr_ovr_i,
  output logic [DATA_WIDTH-1:0] dat_o,
  output logic                  empty_o,
  output logic                  full_o,
  output logic [DEPTH_BITS:0]   count_o,
  output logic                  overrun_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;
  localparam int unsigned CW    = DEPTH_BITS + 1;
  localparam int unsigned PW    = DEPTH_BITS;

  logic                  idle_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [PW-1:0]         wr_ptr_q;
  logic [CW-1:0]         count_q;
  logic                  overrun_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  push_c;
  logic                  full_c;
  logic                  empty_c;
  logic                  do_push_c;
  logic                  do_pop_c;
  logic                  ovr_set_c;
  logic [DATA_WIDTH-1:0] just_c;
  logic [31:0]           shamt_c;
  logic [CW-1:0]         count_nxt_c;

  // Previous receiver idle level, used to find the end-of-frame edge
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      idle_q <= 1'b1;
    end else begin
      idle_q <= rx_idle_i;
    end
  end

  // One-cycle push strobe on the idle rising edge
  assign push_c = rx_idle_i & ~idle_q;

  // Right-justify the received bits; out-of-range lengths pass the word through unchanged
  always_comb begin
    shamt_c = 32'd0;
    just_c  = rx_dat_i;
    if ((bits_i != 6'd0) && (32'(bits_i) <= DATA_WIDTH)) begin
      shamt_c = 32'(DATA_WIDTH) - 32'(bits_i);
      just_c  = rx_dat_i >> shamt_c;
    end
  end

  // Status derived from the registered count, never from a pointer compare
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));

  // Pop only when something is stored; a pop on a full FIFO frees a slot for a coincident push
  always_comb begin
    do_pop_c  = pop_i & ~empty_c;
    do_push_c = push_c & (~full_c | do_pop_c);
    ovr_set_c = push_c & full_c & ~do_pop_c;
  end

  // Next entry count from the accepted push/pop pair
  always_comb begin
    count_nxt_c = count_q;
    case ({do_push_c, do_pop_c})
      2'b10:   count_nxt_c = count_q + CW'(1);
      2'b01:   count_nxt_c = count_q - CW'(1);
      default: count_nxt_c = count_q;
    endcase
  end

  // Pointers and count; flush discards everything including same-cycle push/pop
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push_c) begin
        wr_ptr_q <= wr_ptr_q + PW'(1);
      end
      if (do_pop_c) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      count_q <= count_nxt_c;
    end
  end

  // Storage array; contents need no reset since count gates visibility
  always_ff @(posedge clk_i) begin
    if (do_push_c && !flush_i) begin
      mem_q[wr_ptr_q] <= just_c;
    end
  end

  // Sticky overrun; a new overrun wins over a same-cycle clear, flush leaves it alone
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      overrun_q <= 1'b0;
    end else if (ovr_set_c) begin
      overrun_q <= 1'b1;
    end else if (clr_ovr_i) begin
      overrun_q <= 1'b0;
    end
  end

  // First-word-fall-through head, forced to zero when empty
  always_comb begin
    dat_o = '0;
    if (!empty_c) begin
      dat_o = mem_q[rd_ptr_q];
    end
  end

  assign empty_o   = empty_c;
  assign full_o    = full_c;
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule

// File: tb/tb_sia_rx_fifo.sv
// Bench for sia_rx_fifo: directed frames, scoreboard of expected words, monitor on pops.
module tb_sia_rx_fifo;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic [15:0] rx_dat_i;
  logic        rx_idle_i;
  logic [5:0]  bits_i;
  logic        pop_i;
  logic        flush_i;
  logic        clr_ovr_i;
  logic [15:0] dat_o;
  logic        empty_o;
  logic        full_o;
  logic [4:0]  count_o;
  logic        overrun_o;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  sia_rx_fifo #(.DATA_WIDTH(16), .DEPTH_BITS(4)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .rx_dat_i  (rx_dat_i),
    .rx_idle_i (rx_idle_i),
    .bits_i    (bits_i),
    .pop_i     (pop_i),
    .flush_i   (flush_i),
    .clr_ovr_i (clr_ovr_i),
    .dat_o     (dat_o),
    .empty_o   (empty_o),
    .full_o    (full_o),
    .count_o   (count_o),
    .overrun_o (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: every accepted pop must present the oldest expected word
  always @(negedge clk_i) begin
    if (!reset_i && pop_i && !empty_o) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL pop_data: got %h but no word expected", dat_o);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (dat_o !== e) begin
          bad++;
          $display("FAIL pop_data: got %h expected %h", dat_o, e);
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame: idle low for one cycle, then idle high gives the push strobe cycle
  task automatic frame(input logic [15:0] d, input logic [5:0] b, input bit keep,
                       input logic [15:0] e, input bit with_pop, input bit with_flush);
    rx_idle_i = 1'b0;
    rx_dat_i  = d;
    bits_i    = b;
    tick();
    rx_idle_i = 1'b1;
    pop_i     = with_pop;
    flush_i   = with_flush;
    if (keep) exp_q.push_back(e);
    tick();
    pop_i   = 1'b0;
    flush_i = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      pop_i = 1'b1;
      tick();
      pop_i = 1'b0;
    end
  endtask

  initial begin
    reset_i = 1'b1; rx_dat_i = '0; rx_idle_i = 1'b1; bits_i = 6'd16;
    pop_i = 1'b0; flush_i = 1'b0; clr_ovr_i = 1'b0;
    #12;
    check("rst_dat", 32'(dat_o), 32'h0);
    check("rst_empty", 32'(empty_o), 32'd1);
    check("rst_full", 32'(full_o), 32'd0);
    check("rst_count", 32'(count_o), 32'd0);
    check("rst_ovr", 32'(overrun_o), 32'd0);
    reset_i = 1'b0;
    tick();
    tick();
    check("no_spurious_push", 32'(count_o), 32'd0);

    // 1: basic capture and justification
    frame(16'hA500, 6'd8, 1'b1, 16'h00A5, 1'b0, 1'b0);
    check("t1_dat", 32'(dat_o), 32'h00A5);
    check("t1_count", 32'(count_o), 32'd1);
    check("t1_empty", 32'(empty_o), 32'd0);
    pop_n(1);
    check("t1_count_after_pop", 32'(count_o), 32'd0);
    frame(16'hF000, 6'd4,  1'b1, 16'h000F, 1'b0, 1'b0);
    frame(16'h8000, 6'd1,  1'b1, 16'h0001, 1'b0, 1'b0);
    frame(16'h1234, 6'd20, 1'b1, 16'h1234, 1'b0, 1'b0);
    frame(16'hC3A5, 6'd16, 1'b1, 16'hC3A5, 1'b0, 1'b0);
    frame(16'hABC0, 6'd12, 1'b1, 16'h0ABC, 1'b0, 1'b0);
    check("just_count", 32'(count_o), 32'd5);
    pop_n(5);
    check("just_empty", 32'(empty_o), 32'd1);

    // 2: fill, overrun drops the 17th word
    for (int i = 1; i <= 16; i++) frame(16'(i), 6'd16, 1'b1, 16'(i), 1'b0, 1'b0);
    frame(16'hBEEF, 6'd16, 1'b0, 16'h0, 1'b0, 1'b0);
    check("t2_full", 32'(full_o), 32'd1);
    check("t2_ovr", 32'(overrun_o), 32'd1);
    check("t2_count", 32'(count_o), 32'd16);
    pop_n(16);
    check("t2_empty", 32'(empty_o), 32'd1);
    check("t2_dat_empty", 32'(dat_o), 32'h0);
    clr_ovr_i = 1'b1; tick(); clr_ovr_i = 1'b0;
    check("t2_clr_ovr", 32'(overrun_o), 32'd0);

    // 3: full with coincident pop and push
    for (int i = 0; i < 16; i++) frame(16'h0100 + 16'(i), 6'd16, 1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    frame(16'h1234, 6'd16, 1'b1, 16'h1234, 1'b1, 1'b0);
    check("t3_count", 32'(count_o), 32'd16);
    check("t3_ovr", 32'(overrun_o), 32'd0);
    pop_n(16);
    check("t3_empty", 32'(empty_o), 32'd1);
    check("t3_sb_drained", 32'(exp_q.size()), 32'd0);

    // 4: empty with coincident pop and push, then pop on empty
    frame(16'h00FF, 6'd0, 1'b1, 16'h00FF, 1'b1, 1'b0);
    check("t4_count", 32'(count_o), 32'd1);
    check("t4_dat", 32'(dat_o), 32'h00FF);
    pop_n(1);
    pop_n(1);
    check("t4_empty_pop_count", 32'(count_o), 32'd0);
    check("t4_empty_pop_dat", 32'(dat_o), 32'h0);

    // 5: flush with push strobe keeps overrun
    for (int i = 0; i < 16; i++) frame(16'h0200 + 16'(i), 6'd16, 1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    frame(16'hDEAD, 6'd16, 1'b0, 16'h0, 1'b0, 1'b0);
    pop_n(13);
    check("t5_count3", 32'(count_o), 32'd3);
    check("t5_ovr_set", 32'(overrun_o), 32'd1);
    frame(16'h7777, 6'd16, 1'b0, 16'h0, 1'b0, 1'b1);
    exp_q.delete();
    check("t5_count", 32'(count_o), 32'd0);
    check("t5_empty", 32'(empty_o), 32'd1);
    check("t5_ovr_kept", 32'(overrun_o), 32'd1);
    clr_ovr_i = 1'b1; tick(); clr_ovr_i = 1'b0;
    check("t5_clr", 32'(overrun_o), 32'd0);

    // 6: asynchronous reset mid-operation
    for (int i = 0; i < 5; i++) frame(16'h0300 + 16'(i), 6'd16, 1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    check("t6_count5", 32'(count_o), 32'd5);
    #2 reset_i = 1'b1;
    #1;
    check("t6_rst_count", 32'(count_o), 32'd0);
    check("t6_rst_empty", 32'(empty_o), 32'd1);
    check("t6_rst_dat", 32'(dat_o), 32'h0);
    exp_q.delete();
    #3 reset_i = 1'b0;
    tick();
    tick();
    tick();
    check("t6_no_push", 32'(count_o), 32'd0);
    frame(16'h4200, 6'd8, 1'b1, 16'h0042, 1'b0, 1'b0);
    check("t6_post_count", 32'(count_o), 32'd1);
    pop_n(1);
    check("t6_sb_drained", 32'(exp_q.size()), 32'd0);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
